// File: rtl/control_general_if.sv
// Handshake bundle between the general sequencer and its sub-controllers/decoder.
// The sequencer uses the master view; the surrounding logic uses the slave view.
interface control_general_if;
    logic       fin_I;
    logic       fin_W;
    logic       fin_L;
    logic       req_W;
    logic [3:0] ctrl_G;
    logic       ack_W;
    logic       busy;
    logic       error;

    modport master (
        input  fin_I, fin_W, fin_L, req_W,
        output ctrl_G, ack_W, busy, error
    );

    modport slave (
        output fin_I, fin_W, fin_L, req_W,
        input  ctrl_G, ack_W, busy, error
    );
endinterface

// File: rtl/control_general.sv
// Moore sequencer for the time-keeper access sequence; the state register is ctrl_G.
// One shared 16-bit counter times power-up, refresh and wait-state timeouts.
module control_general #(
    parameter int unsigned POWERUP_CYCLES = 100,
    parameter int unsigned REFRESH_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic               clk,
    input  logic               reset,
    control_general_if.master  bus
);
    typedef enum logic [3:0] {
        S_A = 4'd0,
        S_B = 4'd1,
        S_C = 4'd2,
        S_D = 4'd3,
        S_E = 4'd4,
        S_F = 4'd5,
        S_G = 4'd6,
        S_H = 4'd7,
        S_I = 4'd8
    } state_t;

    localparam logic [15:0] PU_LAST = 16'(POWERUP_CYCLES - 1);
    localparam logic [15:0] RF_LAST = 16'(REFRESH_CYCLES - 1);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_A: if (cnt_q == PU_LAST) state_d = S_B;
            S_B: state_d = S_C;
            // A done pulse takes priority over a timeout in the same cycle.
            S_C: begin
                if (bus.fin_I)             state_d = S_F;
                else if (cnt_q == TO_LAST) state_d = S_I;
            end
            S_D: state_d = S_E;
            S_E: begin
                if (bus.fin_W)             state_d = S_F;
                else if (cnt_q == TO_LAST) state_d = S_I;
            end
            S_F: state_d = S_G;
            S_G: begin
                if (bus.fin_L)             state_d = S_H;
                else if (cnt_q == TO_LAST) state_d = S_I;
            end
            S_H: begin
                if (pend_q || bus.req_W)   state_d = S_D;
                else if (cnt_q == RF_LAST) state_d = S_F;
            end
            S_I:     state_d = S_A;
            default: state_d = S_A;
        endcase
    end

    always_comb begin
        cnt_d   = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;
        // A request arriving on the same cycle as the launch is kept for one more write.
        pend_d  = bus.req_W | (pend_q & (state_d != S_D));
        ack_d   = (state_d == S_D);
        busy_d  = (state_d != S_H);
        error_d = error_q | (state_d == S_I);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_A;
            cnt_q   <= 16'd0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            error_q <= error_d;
        end
    end

    assign bus.ctrl_G = state_q;
    assign bus.ack_W  = ack_q;
    assign bus.busy   = busy_q;
    assign bus.error  = error_q;
endmodule

// File: tb/tb_control_general.sv
// Directed, table-driven bench for control_general (POWERUP=4, REFRESH=10, TIMEOUT=8).
// Each table row is one clock: inputs driven for that cycle, outputs expected after the edge.
module tb_control_general;
    logic clk;
    logic reset;

    control_general_if bus ();

    control_general #(
        .POWERUP_CYCLES(4),
        .REFRESH_CYCLES(10),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rq;
        logic       fi;
        logic       fw;
        logic       fl;
        logic [3:0] g;
        logic       ack;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t vecs[$];
    int   n_pass;
    int   n_total;

    task automatic add(input logic rst, input logic rq, input logic fi, input logic fw,
                       input logic fl, input logic [3:0] g, input logic ack,
                       input logic busy, input logic err);
        vec_t v;
        v.rst = rst; v.rq = rq; v.fi = fi; v.fw = fw; v.fl = fl;
        v.g = g; v.ack = ack; v.busy = busy; v.err = err;
        vecs.push_back(v);
    endtask

    // n idle cycles (no inputs) with the same expected outputs
    task automatic addn(input int n, input logic [3:0] g, input logic ack,
                        input logic busy, input logic err);
        for (int k = 0; k < n; k++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, g, ack, busy, err);
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s row %0d: got %0d expected %0d", nm, idx, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int h_len;
        int n;
        n_pass  = 0;
        n_total = 0;
        reset      = 1'b1;
        bus.req_W  = 1'b0;
        bus.fin_I  = 1'b0;
        bus.fin_W  = 1'b0;
        bus.fin_L  = 1'b0;

        // Reset, power-up wait of 4 cycles, start init, wait init.
        add(1,0,0,0,0, 4'd0,0,1,0);
        add(1,0,0,0,0, 4'd0,0,1,0);
        addn(3, 4'd0,0,1,0);
        add(0,0,0,0,0, 4'd1,0,1,0);
        add(0,0,0,0,0, 4'd2,0,1,0);
        add(0,0,0,0,0, 4'd2,0,1,0);
        add(0,0,0,0,1, 4'd2,0,1,0);   // stray fin_L in c: ignored
        add(0,0,1,0,0, 4'd5,0,1,0);   // fin_I on 3rd cycle of c
        add(0,0,0,0,0, 4'd6,0,1,0);
        add(0,0,0,0,0, 4'd6,0,1,0);
        add(0,0,0,0,1, 4'd7,0,0,0);   // h, cycle 1
        add(0,0,0,0,0, 4'd7,0,0,0);
        add(0,0,0,0,1, 4'd7,0,0,0);   // stray done pulses in h: no effect
        add(0,0,1,0,0, 4'd7,0,0,0);
        add(0,0,0,1,0, 4'd7,0,0,0);
        addn(5, 4'd7,0,0,0);          // h cycles 6..10
        add(0,0,0,0,0, 4'd5,0,1,0);   // refresh read
        add(0,0,0,0,0, 4'd6,0,1,0);
        add(0,0,0,0,1, 4'd7,0,0,0);
        // Write request in h; second request during e.
        add(0,1,0,0,0, 4'd3,1,1,0);
        add(0,0,0,0,0, 4'd4,0,1,0);
        add(0,0,0,0,0, 4'd4,0,1,0);
        add(0,1,0,0,0, 4'd4,0,1,0);
        add(0,0,0,1,0, 4'd5,0,1,0);
        add(0,0,0,0,0, 4'd6,0,1,0);
        add(0,0,0,0,1, 4'd7,0,0,0);
        add(0,0,0,0,0, 4'd3,1,1,0);   // pending write served after one h cycle
        add(0,0,0,0,0, 4'd4,0,1,0);
        // fin_W on the 8th cycle of e beats the timeout.
        addn(7, 4'd4,0,1,0);
        add(0,0,0,1,0, 4'd5,0,1,0);
        add(0,0,0,0,0, 4'd6,0,1,0);
        add(0,0,0,0,1, 4'd7,0,0,0);
        // Request coincident with entry to d: exactly two writes.
        add(0,1,0,0,0, 4'd3,1,1,0);
        add(0,0,0,0,0, 4'd4,0,1,0);
        add(0,0,0,1,0, 4'd5,0,1,0);
        add(0,0,0,0,0, 4'd6,0,1,0);
        add(0,0,0,0,1, 4'd7,0,0,0);
        add(0,0,0,0,0, 4'd3,1,1,0);
        add(0,0,0,0,0, 4'd4,0,1,0);
        add(0,0,0,1,0, 4'd5,0,1,0);
        add(0,0,0,0,0, 4'd6,0,1,0);
        add(0,0,0,0,1, 4'd7,0,0,0);
        addn(3, 4'd7,0,0,0);          // no third write
        // Timeout in e (leaves a pending write), recovery, timeout in c.
        add(0,1,0,0,0, 4'd3,1,1,0);
        add(0,0,0,0,0, 4'd4,0,1,0);
        addn(7, 4'd4,0,1,0);
        add(0,0,0,0,0, 4'd8,0,1,1);
        add(0,0,0,0,0, 4'd0,0,1,1);
        addn(3, 4'd0,0,1,1);
        add(0,0,0,0,0, 4'd1,0,1,1);
        add(0,0,0,0,0, 4'd2,0,1,1);
        addn(7, 4'd2,0,1,1);
        add(0,0,0,0,0, 4'd8,0,1,1);
        add(0,0,0,0,0, 4'd0,0,1,1);
        addn(3, 4'd0,0,1,1);
        add(0,0,0,0,0, 4'd1,0,1,1);
        add(0,0,0,0,0, 4'd2,0,1,1);
        add(0,0,1,0,0, 4'd5,0,1,1);
        add(0,0,0,0,0, 4'd6,0,1,1);
        add(0,0,0,0,1, 4'd7,0,0,1);
        add(0,0,0,0,0, 4'd3,1,1,1);   // write pending since before the timeout
        add(0,0,0,0,0, 4'd4,0,1,1);
        add(0,1,0,0,0, 4'd4,0,1,1);   // pend set, error set
        // Reset mid-wait clears everything including the pending write.
        add(1,0,0,0,0, 4'd0,0,1,0);
        addn(3, 4'd0,0,1,0);
        add(0,0,0,0,0, 4'd1,0,1,0);
        add(0,0,0,0,0, 4'd2,0,1,0);
        add(0,0,1,0,0, 4'd5,0,1,0);
        add(0,0,0,0,0, 4'd6,0,1,0);
        add(0,0,0,0,1, 4'd7,0,0,0);
        addn(6, 4'd7,0,0,0);

        foreach (vecs[i]) begin
            reset     = vecs[i].rst;
            bus.req_W = vecs[i].rq;
            bus.fin_I = vecs[i].fi;
            bus.fin_W = vecs[i].fw;
            bus.fin_L = vecs[i].fl;
            tick();
            chk("ctrl_G", i, 16'(bus.ctrl_G), 16'(vecs[i].g));
            chk("ack_W",  i, 16'(bus.ack_W),  16'(vecs[i].ack));
            chk("busy",   i, 16'(bus.busy),   16'(vecs[i].busy));
            chk("error",  i, 16'(bus.error),  16'(vecs[i].err));
            $display("row %0d: rst=%b req=%b fin=%b%b%b -> ctrl_G=%0d ack=%b busy=%b err=%b",
                     i, vecs[i].rst, vecs[i].rq, vecs[i].fi, vecs[i].fw, vecs[i].fl,
                     bus.ctrl_G, bus.ack_W, bus.busy, bus.error);
        end
        reset     = 1'b0;
        bus.req_W = 1'b0;
        bus.fin_I = 1'b0;
        bus.fin_W = 1'b0;
        bus.fin_L = 1'b0;

        // Hand sequence: ride out the current h into the refresh read, then time a full h.
        n = 0;
        while (bus.ctrl_G != 4'd6 && n < 20) begin
            tick();
            n++;
        end
        chk("reach_g", n, 16'(bus.ctrl_G), 16'd6);
        $display("refresh read reached after %0d cycles", n);
        bus.fin_L = 1'b1;
        tick();
        bus.fin_L = 1'b0;
        chk("h_entry", 0, 16'(bus.ctrl_G), 16'd7);
        h_len = 1;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.ctrl_G == 4'd7) h_len++;
            else break;
        end
        chk("h_len", 0, 16'(h_len), 16'd10);
        chk("after_h", 0, 16'(bus.ctrl_G), 16'd5);
        $display("idle lasted %0d cycles, then ctrl_G=%0d", h_len, bus.ctrl_G);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
